// File: rtl/fir_sample_packer.sv
// rtl/fir_sample_packer.sv - gathers serial sample pairs into packed FIR beats behind a small output FIFO
// Optional partial-beat flush input is enabled by defining PACKER_FLUSH_EN.
module fir_sample_packer #(
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNELS    = 2,
    parameter int P_SAMPLES   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_BEATS = 16
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [DATA_WIDTH-1:0]                    in_ch0,
    input  logic [DATA_WIDTH-1:0]                    in_ch1,
`ifdef PACKER_FLUSH_EN
    input  logic                                     in_flush,
`endif
    output logic                                     m_tvalid,
    input  logic                                     m_tready,
    output logic [CHANNELS*P_SAMPLES*DATA_WIDTH-1:0] m_tdata,
    output logic                                     m_tlast,
    output logic [$clog2(FIFO_DEPTH):0]              fifo_level
);

    localparam int BEAT_W   = CHANNELS * P_SAMPLES * DATA_WIDTH;
    localparam int LANE_OFS = P_SAMPLES * DATA_WIDTH;
    localparam int IDX_W    = (P_SAMPLES > 1) ? $clog2(P_SAMPLES) : 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int FRM_W    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(P_SAMPLES - 1);
    localparam logic [FRM_W-1:0] LAST_FRM  = FRM_W'(FRAME_BEATS - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BEAT_W-1:0] gather_q, gather_d, beat_w;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic [BEAT_W:0]   mem_q [FIFO_DEPTH];
    logic [BEAT_W:0]   head;
    logic [IDX_W-1:0]  lane;
    logic full, empty, accept, complete, flush_req, flush_fire, push, pop;

`ifdef PACKER_FLUSH_EN
    assign flush_req = in_flush;
`else
    assign flush_req = 1'b0;
`endif

    assign full       = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty      = (level_q == '0);
    // Stall only the completing sample; partial gathers never need FIFO space.
    assign in_ready   = nrst && !((idx_q == LAST_IDX) && full);
    assign accept     = in_valid && in_ready;
    assign complete   = accept && (idx_q == LAST_IDX);
    assign flush_fire = flush_req && (idx_q != '0) && !full && !complete;
    assign push       = complete || flush_fire;
    assign pop        = !empty && m_tready;
    assign lane       = LAST_IDX - idx_q;

    always_comb begin
        beat_w = gather_q;
        if (accept) begin
            beat_w[DATA_WIDTH*lane +: DATA_WIDTH]            = in_ch0;
            beat_w[LANE_OFS + DATA_WIDTH*lane +: DATA_WIDTH] = in_ch1;
        end
        // Clearing on push makes a flushed beat's unfilled lanes read as zero.
        gather_d = push ? '0 : beat_w;
        idx_d    = idx_q;
        if (push) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = idx_q + 1'b1;
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        frame_d = frame_q;
        if (push) begin
            frame_d = (frame_q == LAST_FRM) ? '0 : frame_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q    <= '0;
            gather_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            frame_q  <= '0;
        end else begin
            idx_q    <= idx_d;
            gather_q <= gather_d;
            level_q  <= level_d;
            frame_q  <= frame_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the level counter gates every output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {(frame_q == LAST_FRM), beat_w};
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign m_tvalid   = !empty;
    assign m_tdata    = empty ? '0 : head[BEAT_W-1:0];
    assign m_tlast    = !empty && head[BEAT_W];
    assign fifo_level = level_q;

endmodule

// File: tb/tb_fir_sample_packer.sv
// tb/tb_fir_sample_packer.sv - randomized scoreboard bench for fir_sample_packer
module tb_fir_sample_packer;

    localparam int DW     = 16;
    localparam int P      = 8;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 16;
    localparam int BEAT_W = 2 * P * DW;
`ifdef PACKER_FLUSH_EN
    localparam bit HAS_FLUSH = 1'b1;
`else
    localparam bit HAS_FLUSH = 1'b0;
`endif

    typedef struct {
        logic [BEAT_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_ch0 = '0;
    logic [DW-1:0]     in_ch1 = '0;
    logic              in_flush_tb = 1'b0;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [BEAT_W-1:0] m_tdata;
    logic              m_tlast;
    logic [$clog2(DEPTH):0] fifo_level;

    int n_checks = 0;
    int n_pass   = 0;

    beat_t         exp_q[$];
    logic [DW-1:0] pend_c0[$];
    logic [DW-1:0] pend_c1[$];
    int            frame_cnt = 0;
    int            pop_idx = 0;
    logic [31:0]   tlast_mask = '0;

    fir_sample_packer dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch0     (in_ch0),
        .in_ch1     (in_ch1),
`ifdef PACKER_FLUSH_EN
        .in_flush   (in_flush_tb),
`endif
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Model beat: k-th gathered pair sits in lane P-1-k, missing lanes are zero.
    function automatic beat_t model_beat();
        beat_t b;
        b.data = '0;
        for (int k = 0; k < pend_c0.size(); k++) begin
            b.data[DW*(P-1-k) +: DW]        = pend_c0[k];
            b.data[P*DW + DW*(P-1-k) +: DW] = pend_c1[k];
        end
        b.last = (frame_cnt == FRAME - 1);
        frame_cnt = (frame_cnt + 1) % FRAME;
        return b;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend_c0.delete();
        pend_c1.delete();
        frame_cnt = 0;
    endtask

    // One cycle; called just after a negedge.
    task automatic step(input logic v, input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                        input logic rdy, input logic fl);
        logic exp_ready, pop, acc, full_before, done;
        int   n_before;
        beat_t b;
        in_valid = v; in_ch0 = c0; in_ch1 = c1; m_tready = rdy; in_flush_tb = fl;
        #1;
        exp_ready = !(pend_c0.size() == P - 1 && exp_q.size() == DEPTH);
        check("in_ready", BEAT_W'(in_ready), BEAT_W'(exp_ready));
        check("m_tvalid", BEAT_W'(m_tvalid), BEAT_W'(exp_q.size() != 0));
        check("fifo_level", BEAT_W'(fifo_level), BEAT_W'(exp_q.size()));
        if (exp_q.size() != 0) begin
            check("m_tdata", m_tdata, exp_q[0].data);
            check("m_tlast", BEAT_W'(m_tlast), BEAT_W'(exp_q[0].last));
        end
        pop = (exp_q.size() != 0) && rdy;
        acc = v && exp_ready;
        full_before = (exp_q.size() == DEPTH);
        n_before = pend_c0.size();
        if (pop && pop_idx < 32) tlast_mask[pop_idx] = m_tlast;
        @(posedge clk);
        if (pop) begin
            void'(exp_q.pop_front());
            pop_idx++;
        end
        done = 1'b0;
        if (acc) begin
            pend_c0.push_back(c0);
            pend_c1.push_back(c1);
            if (pend_c0.size() == P) begin
                b = model_beat();
                exp_q.push_back(b);
                pend_c0.delete(); pend_c1.delete();
                done = 1'b1;
            end
        end
        if (HAS_FLUSH && fl && !done && n_before > 0 && !full_before) begin
            b = model_beat();
            exp_q.push_back(b);
            pend_c0.delete(); pend_c1.delete();
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_flush_tb = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #1;
        check("rst_tvalid", BEAT_W'(m_tvalid), '0);
        check("rst_tdata", m_tdata, '0);
        check("rst_tlast", BEAT_W'(m_tlast), '0);
        check("rst_level", BEAT_W'(fifo_level), '0);
        check("rst_in_ready", BEAT_W'(in_ready), '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Directed first beat
        for (int k = 0; k < P; k++) step(1'b1, DW'(k + 1), DW'(16'h100 + k), 1'b1, 1'b0);
        check("first_tvalid", BEAT_W'(m_tvalid), BEAT_W'(1));
        check("lane0_ch0", BEAT_W'(m_tdata[15:0]), BEAT_W'(16'h0008));
        check("lane7_ch0", BEAT_W'(m_tdata[127:112]), BEAT_W'(16'h0001));
        check("lane0_ch1", BEAT_W'(m_tdata[143:128]), BEAT_W'(16'h0107));
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure fill: 5 beats offered, 4 buffered, stall at idx 7
        for (int i = 0; i < 5 * P; i++) step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        check("full_level", BEAT_W'(fifo_level), BEAT_W'(DEPTH));
        check("stall_in_ready", BEAT_W'(in_ready), '0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Toggled ready with continuous input
        for (int i = 0; i < 120; i++) step(1'b1, DW'($urandom), DW'($urandom), 1'(i % 2), 1'b0);

        // Random traffic
        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 3) != 0), DW'($urandom), DW'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));

        // Frame tagging over 32 continuous beats
        @(negedge clk);
        do_reset();
        pop_idx = 0;
        tlast_mask = '0;
        for (int i = 0; i < 32 * P; i++) step(1'b1, DW'($urandom), DW'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        check("tlast_positions", BEAT_W'(tlast_mask), BEAT_W'(32'h8000_8000));
        check("beats_out", BEAT_W'(pop_idx), BEAT_W'(32));

        // Reset with 2 beats buffered and 3 pairs gathered
        for (int i = 0; i < 2 * P + 3; i++) step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        check("pre_rst_level", BEAT_W'(fifo_level), BEAT_W'(2));
        do_reset();
        for (int k = 0; k < P; k++) step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
        check("post_rst_level", BEAT_W'(fifo_level), BEAT_W'(1));
        check("post_rst_tlast", BEAT_W'(m_tlast), '0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

`ifdef PACKER_FLUSH_EN
        step(1'b1, 16'h11, 16'h11, 1'b0, 1'b0);
        step(1'b1, 16'h22, 16'h22, 1'b0, 1'b0);
        step(1'b1, 16'h33, 16'h33, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("flush_lane7", BEAT_W'(m_tdata[127:112]), BEAT_W'(16'h11));
        check("flush_lane6", BEAT_W'(m_tdata[111:96]), BEAT_W'(16'h22));
        check("flush_lane5", BEAT_W'(m_tdata[95:80]), BEAT_W'(16'h33));
        check("flush_lanes4_0", BEAT_W'(m_tdata[79:0]), '0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("flush_idx0_noop", BEAT_W'(fifo_level), BEAT_W'(1));
        step(1'b0, '0, '0, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
